seq_serializer: RTL and testbench



---
 rtl/seq_serializer.sv | 178 +++++++++++++++++
 tb/tb_seq_serializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the serial sequence detector.
// Words are taken over a valid/ready handshake and shifted out one bit per clock,
// MSB- or LSB-first as selected at accept time, with an optional idle gap after each word.
module seq_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned GAP      = 0,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             msb_first,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int unsigned CntW = $clog2(WIDTH);
  // Gap counter needs at least one bit even when GAP is 0 or 1.
  localparam int unsigned GapW = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             msb_q, msb_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic [15:0]      words_q;

  logic             accept;
  logic             word_done;
  logic             load_bit;
  logic [WIDTH-1:0] load_rest;
  logic             cur_bit;
  logic [WIDTH-1:0] cur_rest;

  // Ready depends only on state/counters; held low while in reset.
  always_comb begin
    data_ready = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle:  data_ready = 1'b1;
        StShift: data_ready = (GAP == 0) && (cnt_q == CntLast);
        StGap:   data_ready = (gap_q == GapLast);
        default: data_ready = 1'b0;
      endcase
    end
  end

  assign accept    = data_valid && data_ready;
  assign word_done = (state_q == StShift) && (cnt_q == CntLast);

  // The first bit is taken straight from data_in so it is on dout the cycle after accept;
  // the shift register keeps the remaining bits aligned at the outgoing end.
  always_comb begin
    load_bit  = msb_first ? data_in[WIDTH-1] : data_in[0];
    load_rest = msb_first ? {data_in[WIDTH-2:0], 1'b0} : {1'b0, data_in[WIDTH-1:1]};
    cur_bit   = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
    cur_rest  = msb_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    shreg_d       = shreg_q;
    msb_d         = msb_q;
    dout_d        = IDLE_BIT;
    dout_valid_d  = 1'b0;
    frame_start_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d       = StShift;
          cnt_d         = '0;
          msb_d         = msb_first;
          shreg_d       = load_rest;
          dout_d        = load_bit;
          dout_valid_d  = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      StShift: begin
        if (cnt_q != CntLast) begin
          cnt_d        = cnt_q + CntW'(1);
          shreg_d      = cur_rest;
          dout_d       = cur_bit;
          dout_valid_d = 1'b1;
        end else if (GAP > 0) begin
          state_d = StGap;
          gap_d   = '0;
        end else if (accept) begin
          // Back-to-back reload: next word's first bit follows with no bubble.
          cnt_d         = '0;
          msb_d         = msb_first;
          shreg_d       = load_rest;
          dout_d        = load_bit;
          dout_valid_d  = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q != GapLast) begin
          gap_d = gap_q + GapW'(1);
        end else if (accept) begin
          state_d       = StShift;
          cnt_d         = '0;
          msb_d         = msb_first;
          shreg_d       = load_rest;
          dout_d        = load_bit;
          dout_valid_d  = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      gap_q         <= '0;
      shreg_q       <= '0;
      msb_q         <= 1'b1;
      dout_q        <= IDLE_BIT;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      shreg_q       <= shreg_d;
      msb_q         <= msb_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  // Sent-word counter: bumps on the edge that ends a word's last bit, wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q <= '0;
    end else if (word_done) begin
      words_q <= words_q + 16'd1;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign words_sent  = words_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: one instance streaming back-to-back (GAP=0, idle 0) and one
// with a two-cycle gap (GAP=2, idle 1), checked every cycle against a word-level model.
module tb_seq_serializer;

  localparam int unsigned W      = 8;
  localparam int          MaxCyc = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] din    [2];
  logic         dvalid [2];
  logic         msb    [2];
  logic         dready [2];
  logic         dout   [2];
  logic         dv     [2];
  logic         fs     [2];
  logic         busy   [2];
  logic [15:0]  ws     [2];

  seq_serializer #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(dvalid[0]),
    .data_ready(dready[0]), .msb_first(msb[0]), .dout(dout[0]), .dout_valid(dv[0]),
    .frame_start(fs[0]), .busy(busy[0]), .words_sent(ws[0])
  );

  seq_serializer #(.WIDTH(W), .GAP(2), .IDLE_BIT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(dvalid[1]),
    .data_ready(dready[1]), .msb_first(msb[1]), .dout(dout[1]), .dout_valid(dv[1]),
    .frame_start(fs[1]), .busy(busy[1]), .words_sent(ws[1])
  );

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic idle_of(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  // Word-level model: each accepted word is expanded into a per-cycle bit schedule.
  int          cyc = 0;
  int          free_at    [2];
  int          busy_until [2];
  logic [15:0] words_m    [2];
  bit          exp_v      [2][MaxCyc];
  bit          exp_b      [2][MaxCyc];
  bit          exp_f      [2][MaxCyc];
  bit          exp_done   [2][MaxCyc];

  logic rec_dout [2][MaxCyc];
  logic rec_dv   [2][MaxCyc];
  logic rec_fs   [2][MaxCyc];
  logic rec_rdy  [2][MaxCyc];
  logic rec_busy [2][MaxCyc];

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  function automatic logic model_ready(input int d);
    return rst_n && (cyc >= free_at[d]);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model update on each rising edge, using input values that are stable across the edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int c = 0; c < MaxCyc; c++) begin
          exp_v[d][c]    = 1'b0;
          exp_done[d][c] = 1'b0;
        end
        words_m[d]    = 16'h0;
        busy_until[d] = -1;
        free_at[d]    = 0;
      end else if (dvalid[d] && model_ready(d)) begin
        for (int i = 0; i < W; i++) begin
          exp_v[d][cyc+1+i] = 1'b1;
          exp_b[d][cyc+1+i] = msb[d] ? din[d][W-1-i] : din[d][i];
          exp_f[d][cyc+1+i] = (i == 0);
        end
        exp_done[d][cyc+W+1] = 1'b1;
        busy_until[d]        = cyc + W + gap_of(d);
        free_at[d]           = cyc + W + gap_of(d);
      end
    end
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (exp_done[d][cyc]) words_m[d] = words_m[d] + 16'd1;
    end
  end

  // Per-cycle comparison on the falling edge, plus a trace for the literal checks.
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        rec_dout[d][cyc] = dout[d];
        rec_dv[d][cyc]   = dv[d];
        rec_fs[d][cyc]   = fs[d];
        rec_rdy[d][cyc]  = dready[d];
        rec_busy[d][cyc] = busy[d];
        chk($sformatf("dut%0d c%0d ready", d, cyc), 16'(dready[d]), 16'(model_ready(d)));
        chk($sformatf("dut%0d c%0d dout", d, cyc), 16'(dout[d]),
            16'(exp_v[d][cyc] ? exp_b[d][cyc] : idle_of(d)));
        chk($sformatf("dut%0d c%0d dout_valid", d, cyc), 16'(dv[d]), 16'(exp_v[d][cyc]));
        chk($sformatf("dut%0d c%0d frame_start", d, cyc), 16'(fs[d]),
            16'(exp_v[d][cyc] && exp_f[d][cyc]));
        chk($sformatf("dut%0d c%0d busy", d, cyc), 16'(busy[d]), 16'(cyc <= busy_until[d]));
        chk($sformatf("dut%0d c%0d words_sent", d, cyc), ws[d], words_m[d]);
      end
    end
  end

  function automatic logic [15:0] get_bits(input int d, input int s, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[14:0], rec_dout[d][s+i]};
    return r;
  endfunction

  function automatic int count_dv(input int d, input int s, input int n);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) if (rec_dv[d][s+i] === 1'b1) k++;
    return k;
  endfunction

  function automatic int count_fs(input int d, input int s, input int n);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) if (rec_fs[d][s+i] === 1'b1) k++;
    return k;
  endfunction

  // Present a word and hold valid until accepted; returns the accepting cycle index.
  task automatic send(input int d, input logic [W-1:0] w, input logic m, output int acc);
    din[d]    = w;
    msb[d]    = m;
    dvalid[d] = 1'b1;
    acc       = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (dready[d] === 1'b1) begin
        acc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      chk($sformatf("dut%0d accept timeout", d), 16'h0, 16'h1);
      acc = 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      din[d]    = '0;
      dvalid[d] = 1'b0;
      msb[d]    = 1'b0;
    end
    @(posedge clk);
    #1;
    checking = 1'b1;
    @(posedge clk);
    #1;
    chk("reset dout0", 16'(dout[0]), 16'h0);
    chk("reset dout1 idle", 16'(dout[1]), 16'h1);
    chk("reset ready held low", 16'(dready[0]), 16'h0);
    rst_n = 1'b1;

    // MSB-first A5 on the streaming instance.
    send(0, 8'hA5, 1'b1, t);
    dvalid[0] = 1'b0;
    idle_cycles(10);
    chk("a5 bits", get_bits(0, t + 1, 8), 16'h00A5);
    chk("a5 valid count", 16'(count_dv(0, t + 1, 10)), 16'd8);
    chk("a5 frame_start first", 16'(rec_fs[0][t+1]), 16'h1);
    chk("a5 frame_start count", 16'(count_fs(0, t + 1, 9)), 16'd1);
    chk("a5 busy after", 16'(rec_busy[0][t+9]), 16'h0);
    chk("a5 words", ws[0], 16'd1);

    // LSB-first 01; input changes mid-word must be ignored.
    send(0, 8'h01, 1'b0, t);
    dvalid[0] = 1'b0;
    din[0]    = 8'hFE;
    msb[0]    = 1'b1;
    idle_cycles(3);
    din[0]    = 8'h7F;
    idle_cycles(8);
    chk("lsb 01 bits", get_bits(0, t + 1, 8), 16'h0080);
    chk("lsb words", ws[0], 16'd2);

    // Back-to-back F0 then 0F with valid held high.
    send(0, 8'hF0, 1'b1, t1);
    send(0, 8'h0F, 1'b1, t2);
    dvalid[0] = 1'b0;
    idle_cycles(12);
    chk("b2b accept spacing", 16'(t2 - t1), 16'd8);
    chk("b2b stream", get_bits(0, t1 + 1, 16), 16'hF00F);
    chk("b2b valid count", 16'(count_dv(0, t1 + 1, 17)), 16'd16);
    chk("b2b frame_start c9", 16'(rec_fs[0][t1+9]), 16'h1);
    chk("b2b frame_start count", 16'(count_fs(0, t1 + 1, 16)), 16'd2);
    chk("b2b ready mid", 16'(rec_rdy[0][t1+4]), 16'h0);
    chk("b2b ready last bit", 16'(rec_rdy[0][t1+8]), 16'h1);
    chk("b2b words", ws[0], 16'd4);

    // Gapped instance: two queued words.
    send(1, 8'h3C, 1'b1, t1);
    send(1, 8'hC1, 1'b0, t2);
    dvalid[1] = 1'b0;
    idle_cycles(14);
    chk("gap accept spacing", 16'(t2 - t1), 16'd10);
    chk("gap w1 bits", get_bits(1, t1 + 1, 8), 16'h003C);
    chk("gap idle dout", {rec_dout[1][t1+9], rec_dout[1][t1+10]}, 16'h3);
    chk("gap idle valid", {rec_dv[1][t1+9], rec_dv[1][t1+10]}, 16'h0);
    chk("gap ready pattern", {rec_rdy[1][t1+9], rec_rdy[1][t1+10]}, 16'h1);
    chk("gap w2 first c11", {rec_dv[1][t1+11], rec_fs[1][t1+11]}, 16'h3);
    chk("gap w2 lsb bits", get_bits(1, t1 + 11, 8), 16'h0083);
    chk("gap words", ws[1], 16'd2);

    // Reset for one cycle after bit 3 of FF, then immediate new word.
    send(0, 8'hFF, 1'b1, t);
    dvalid[0] = 1'b0;
    idle_cycles(2);
    rst_n = 1'b0;
    idle_cycles(1);
    rst_n = 1'b1;
    send(0, 8'h96, 1'b1, t1);
    dvalid[0] = 1'b0;
    idle_cycles(10);
    chk("rst accept next cycle", 16'(t1 - t), 16'd4);
    chk("rst dout", 16'(rec_dout[0][t+4]), 16'h0);
    chk("rst valid", 16'(rec_dv[0][t+4]), 16'h0);
    chk("rst busy", 16'(rec_busy[0][t+4]), 16'h0);
    chk("rst drop bits", get_bits(0, t + 1, 3), 16'h0007);
    chk("rst new word", get_bits(0, t1 + 1, 8), 16'h0096);
    chk("rst words", ws[0], 16'd1);

    // Counter wrap: preload to FFFF, then one more word.
    #1;
    force u_dut0.words_q = 16'hFFFF;
    words_m[0] = 16'hFFFF;
    #1;
    release u_dut0.words_q;
    idle_cycles(2);
    chk("preload held", ws[0], 16'hFFFF);
    send(0, 8'h5A, 1'b0, t);
    dvalid[0] = 1'b0;
    idle_cycles(10);
    chk("wrap words", ws[0], 16'h0000);
    chk("wrap bits", get_bits(0, t + 1, 8), 16'h005A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
